// File: rtl/omap_writeback_ctrl.sv
// Output-map write-back sequencer: snapshots the omap buffer, walks its entries in
// order and issues one handshaked BRAM write per valid entry, then flags tile completion.
module omap_writeback_ctrl #(
  parameter int NUM_PE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tile_start,
  input  logic [NUM_PE-1:0] valid_mask,
  output logic              omap_load,
  output logic [4:0]        done,
  input  logic [3:0]        bram_sel_in,
  input  logic [9:0]        bram_addr_in,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [3:0]        wr_bram_sel,
  output logic [9:0]        wr_addr,
  output logic [3:0]        wr_pe_idx,
  output logic              busy,
  output logic              tile_done,
  output logic [4:0]        wr_count,
  output logic              overrun,
  input  logic              clr_overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [4:0] LAST_DONE = 5'(NUM_PE);

  state_t            state_r;
  logic [NUM_PE-1:0] mask_r;
  logic [15:0]       mask_ext_s;
  logic [3:0]        scan_idx_s;

  // Entry under examination is done-1; mask widened so any NUM_PE indexes with 4 bits.
  assign mask_ext_s = 16'(mask_r);
  assign scan_idx_s = done[3:0] - 4'd1;

  // The buffer must capture its snapshot on the very edge we leave IDLE, hence combinational.
  assign omap_load   = tile_start & (state_r == IDLE);
  assign wr_bram_sel = wr_en ? bram_sel_in  : 4'd0;
  assign wr_addr     = wr_en ? bram_addr_in : 10'd0;

  // Sequencer FSM with registered status and handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      mask_r    <= '0;
      done      <= 5'd0;
      wr_en     <= 1'b0;
      wr_pe_idx <= 4'd0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
      wr_count  <= 5'd0;
      overrun   <= 1'b0;
    end else begin
      // A new overrun takes priority over a simultaneous clear.
      if (tile_start && busy) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end

      case (state_r)
        IDLE: begin
          if (tile_start) begin
            mask_r   <= valid_mask;
            done     <= 5'd1;
            wr_count <= 5'd0;
            busy     <= 1'b1;
            state_r  <= SCAN;
          end else begin
            state_r  <= IDLE;
          end
        end

        SCAN: begin
          if (mask_ext_s[scan_idx_s]) begin
            wr_en     <= 1'b1;
            wr_pe_idx <= scan_idx_s;
            state_r   <= WRITE;
          end else if (done == LAST_DONE) begin
            tile_done <= 1'b1;
            state_r   <= FIN;
          end else begin
            done      <= done + 5'd1;
            state_r   <= SCAN;
          end
        end

        WRITE: begin
          // wr_en is always high here, so wr_ready alone marks the accept.
          if (wr_ready) begin
            wr_en    <= 1'b0;
            wr_count <= wr_count + 5'd1;
            if (done == LAST_DONE) begin
              tile_done <= 1'b1;
              state_r   <= FIN;
            end else begin
              done      <= done + 5'd1;
              state_r   <= SCAN;
            end
          end else begin
            state_r <= WRITE;
          end
        end

        FIN: begin
          tile_done <= 1'b0;
          busy      <= 1'b0;
          done      <= 5'd0;
          state_r   <= IDLE;
        end

        default: begin
          wr_en     <= 1'b0;
          tile_done <= 1'b0;
          busy      <= 1'b0;
          done      <= 5'd0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_omap_writeback_ctrl.sv
// Self-checking bench for omap_writeback_ctrl: scoreboard of expected writes per tile
// plus latency, count, backpressure, overrun and reset scenarios.
module tb_omap_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tile_start;
  logic [15:0] valid_mask;
  logic        omap_load;
  logic [4:0]  done;
  logic [3:0]  bram_sel_in;
  logic [9:0]  bram_addr_in;
  logic        wr_en;
  logic        wr_ready;
  logic [3:0]  wr_bram_sel;
  logic [9:0]  wr_addr;
  logic [3:0]  wr_pe_idx;
  logic        busy;
  logic        tile_done;
  logic [4:0]  wr_count;
  logic        overrun;
  logic        clr_overrun;

  typedef struct packed {
    logic [3:0] sel;
    logic [9:0] addr;
    logic [3:0] pe;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  omap_writeback_ctrl #(.NUM_PE(16)) dut (
    .clk(clk), .rst_n(rst_n), .tile_start(tile_start), .valid_mask(valid_mask),
    .omap_load(omap_load), .done(done), .bram_sel_in(bram_sel_in), .bram_addr_in(bram_addr_in),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_bram_sel(wr_bram_sel), .wr_addr(wr_addr),
    .wr_pe_idx(wr_pe_idx), .busy(busy), .tile_done(tile_done), .wr_count(wr_count),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  // Runs one tile; the omap buffer model returns entry i = {i, 4*i} for done = i+1.
  task automatic run_tile(input logic [15:0] mask, input int stall, input int ovr_cycle,
                          output int td_cycle, output int en_cycles, output int unstable,
                          output logic [4:0] cnt_at_done, output int load_seen);
    wr_t        e;
    wr_t        got;
    int         stall_left;
    logic [3:0] idx;
    logic [9:0] first_addr;
    logic [3:0] first_pe;
    logic       prev_en;
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) begin
        e.sel  = 4'(i);
        e.addr = 10'(i * 4);
        e.pe   = 4'(i);
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    valid_mask = mask;
    tile_start = 1'b1;
    @(posedge clk);
    #1;
    tile_start = 1'b0;
    valid_mask = ~mask;
    td_cycle = 0; en_cycles = 0; unstable = 0; load_seen = 0; cnt_at_done = 5'd31;
    prev_en = 1'b0; stall_left = stall; first_addr = 10'd0; first_pe = 4'd0;
    for (int c = 1; c <= 300 && td_cycle == 0; c++) begin
      @(negedge clk);
      idx = done[3:0] - 4'd1;
      bram_sel_in  = idx;
      bram_addr_in = {4'd0, idx, 2'b00};
      if (wr_en) begin
        wr_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        wr_ready   = 1'b0;
        stall_left = stall;
      end
      tile_start = (c == ovr_cycle);
      if (tile_start) valid_mask = 16'hFFFF;
      #1;
      if (omap_load) load_seen++;
      if (wr_en) begin
        en_cycles++;
        if (prev_en && (wr_addr !== first_addr || wr_pe_idx !== first_pe)) unstable++;
        if (!prev_en) begin
          first_addr = wr_addr;
          first_pe   = wr_pe_idx;
        end
      end else begin
        n_cmp++;
        if (wr_bram_sel !== 4'd0 || wr_addr !== 10'd0) begin
          n_err++;
          $display("FAIL idle_gate: sel=%0h addr=%0h, required 0/0", wr_bram_sel, wr_addr);
        end
      end
      prev_en = wr_en;
      if (wr_en && wr_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_write: pe=%0d written, none expected", wr_pe_idx);
        end else begin
          e   = exp_q.pop_front();
          got = '{sel: wr_bram_sel, addr: wr_addr, pe: wr_pe_idx};
          if (got !== e) begin
            n_err++;
            $display("FAIL write_data: got sel=%0d addr=%0d pe=%0d, required sel=%0d addr=%0d pe=%0d",
                     got.sel, got.addr, got.pe, e.sel, e.addr, e.pe);
          end
        end
      end
      if (tile_done) begin
        td_cycle    = c;
        cnt_at_done = wr_count;
      end
    end
    tile_start = 1'b0;
    wr_ready   = 1'b0;
    n_cmp++;
    if (td_cycle == 0) begin
      n_err++;
      $display("FAIL tile_timeout: tile_done not seen in 300 cycles, required a pulse");
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_writes: %0d left in scoreboard, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({done, wr_en, wr_pe_idx, busy, tile_done, wr_count, overrun, omap_load} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_state: done=%0d wr_en=%0b pe=%0d busy=%0b td=%0b cnt=%0d ovr=%0b load=%0b, required all 0",
               done, wr_en, wr_pe_idx, busy, tile_done, wr_count, overrun, omap_load);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_tile();
    int td, en, un, ld;
    logic [4:0] cnt;
    run_tile(16'hFFFF, 0, 0, td, en, un, cnt, ld);
    n_cmp++; if (td !== 33) begin n_err++; $display("FAIL full_latency: got %0d, required 33", td); end
    n_cmp++; if (cnt !== 5'd16) begin n_err++; $display("FAIL full_count: got %0d, required 16", cnt); end
    n_cmp++; if (en !== 16) begin n_err++; $display("FAIL full_en_cycles: got %0d, required 16", en); end
    n_cmp++; if (ld !== 0) begin n_err++; $display("FAIL full_load: got %0d, required 0", ld); end
  endtask

  task automatic test_sparse();
    int td, en, un, ld;
    logic [4:0] cnt;
    run_tile(16'h8001, 0, 0, td, en, un, cnt, ld);
    n_cmp++; if (td !== 19) begin n_err++; $display("FAIL sparse_latency: got %0d, required 19", td); end
    n_cmp++; if (cnt !== 5'd2) begin n_err++; $display("FAIL sparse_count: got %0d, required 2", cnt); end
  endtask

  task automatic test_backpressure();
    int td, en, un, ld;
    logic [4:0] cnt;
    run_tile(16'h0004, 5, 0, td, en, un, cnt, ld);
    n_cmp++; if (en !== 6) begin n_err++; $display("FAIL bp_en_cycles: got %0d, required 6", en); end
    n_cmp++; if (un !== 0) begin n_err++; $display("FAIL bp_stable: got %0d changes, required 0", un); end
    n_cmp++; if (cnt !== 5'd1) begin n_err++; $display("FAIL bp_count: got %0d, required 1", cnt); end
    n_cmp++; if (td !== 23) begin n_err++; $display("FAIL bp_latency: got %0d, required 23", td); end
  endtask

  task automatic test_empty();
    int td, en, un, ld;
    logic [4:0] cnt;
    run_tile(16'h0000, 0, 0, td, en, un, cnt, ld);
    n_cmp++; if (en !== 0) begin n_err++; $display("FAIL empty_wr_en: got %0d cycles, required 0", en); end
    n_cmp++; if (td !== 17) begin n_err++; $display("FAIL empty_latency: got %0d, required 17", td); end
    n_cmp++; if (cnt !== 5'd0) begin n_err++; $display("FAIL empty_count: got %0d, required 0", cnt); end
  endtask

  task automatic test_back_to_back();
    int td, en, un, ld;
    logic [4:0] cnt;
    run_tile(16'h00F0, 0, 0, td, en, un, cnt, ld);
    n_cmp++; if (td !== 21 || cnt !== 5'd4) begin n_err++; $display("FAIL b2b_first: td=%0d cnt=%0d, required 21/4", td, cnt); end
    run_tile(16'h0003, 0, 0, td, en, un, cnt, ld);
    n_cmp++; if (td !== 19 || cnt !== 5'd2) begin n_err++; $display("FAIL b2b_second: td=%0d cnt=%0d, required 19/2", td, cnt); end
  endtask

  task automatic test_overrun();
    int td, en, un, ld;
    logic [4:0] cnt;
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_initial: got %0b, required 0", overrun); end
    run_tile(16'h0F0F, 0, 5, td, en, un, cnt, ld);
    n_cmp++; if (ld !== 0) begin n_err++; $display("FAIL ovr_load: got %0d, required 0", ld); end
    n_cmp++; if (td !== 25 || cnt !== 5'd8) begin n_err++; $display("FAIL ovr_tile: td=%0d cnt=%0d, required 25/8", td, cnt); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %0b, required 1", overrun); end
    @(negedge clk);
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    clr_overrun = 1'b0;
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %0b, required 0", overrun); end
  endtask

  task automatic test_reset_mid_write();
    logic seen;
    int   pulses;
    @(negedge clk);
    valid_mask = 16'h0004;
    tile_start = 1'b1;
    @(posedge clk);
    #1;
    tile_start = 1'b0;
    wr_ready   = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (wr_en) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL rst_reach_write: wr_en not seen in 20 cycles, required 1"); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({wr_en, busy, done, tile_done, wr_count} !== 13'd0) begin
      n_err++;
      $display("FAIL rst_mid_write: wr_en=%0b busy=%0b done=%0d td=%0b cnt=%0d, required all 0",
               wr_en, busy, done, tile_done, wr_count);
    end
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) rst_n = 1'b1;
      @(negedge clk);
      if (tile_done) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin n_err++; $display("FAIL rst_no_tile_done: got %0d pulses, required 0", pulses); end
  endtask

  initial begin
    rst_n = 1'b0; tile_start = 1'b0; valid_mask = 16'h0000; bram_sel_in = 4'd0;
    bram_addr_in = 10'd0; wr_ready = 1'b0; clr_overrun = 1'b0;
    test_reset();
    test_full_tile();
    test_sparse();
    test_backpressure();
    test_empty();
    test_back_to_back();
    test_overrun();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
